// File: rtl/serial_mag_comparator_pkg.sv
// Shared encodings for the comparator family: FSM states, the one-hot {G,E,L} result
// words, and an index-width helper.
package serial_mag_comparator_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Result words are packed as {G, E, L}.
  localparam logic [2:0] RES_GT = 3'b100;
  localparam logic [2:0] RES_EQ = 3'b010;
  localparam logic [2:0] RES_LT = 3'b001;

  function automatic int unsigned idx_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/bit_cmp_cell.sv
// Combinational 1-bit greater/equal/less stage. Once an earlier bit has decided the
// result (e_in=0), the incoming verdict passes straight through.
module bit_cmp_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic g_in,
  input  logic e_in,
  input  logic l_in,
  input  logic inv,
  output logic g_out,
  output logic e_out,
  output logic l_out
);

  logic bit_gt;
  logic bit_lt;

  always_comb begin
    // The sign bit of a two's-complement value carries negative weight.
    bit_gt = inv ? (~a_i & b_i) : (a_i & ~b_i);
    bit_lt = inv ? (a_i & ~b_i) : (~a_i & b_i);
    g_out  = g_in | (e_in & bit_gt);
    l_out  = l_in | (e_in & bit_lt);
    e_out  = e_in & ~(bit_gt | bit_lt);
  end

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial magnitude comparator: latches both operands on start, then scans them
// MSB-first through one bit_cmp_cell and pulses valid with the held G/E/L result.
module serial_mag_comparator
  import serial_mag_comparator_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter bit          SIGNED     = 1'b0,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             valid,
  output logic             G,
  output logic             E,
  output logic             L
);

  localparam int unsigned    IdxW    = idx_width(WIDTH);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IdxW-1:0]  idx_q;
  logic             gt_q;
  logic             eq_q;
  logic             lt_q;

  logic bit_a;
  logic bit_b;
  logic inv;
  logic g_nxt;
  logic e_nxt;
  logic l_nxt;
  logic done;

  always_comb begin
    bit_a = a_q[idx_q];
    bit_b = b_q[idx_q];
    inv   = SIGNED && (idx_q == LastIdx);
  end

  bit_cmp_cell u_cell (
    .a_i   (bit_a),
    .b_i   (bit_b),
    .g_in  (gt_q),
    .e_in  (eq_q),
    .l_in  (lt_q),
    .inv   (inv),
    .g_out (g_nxt),
    .e_out (e_nxt),
    .l_out (l_nxt)
  );

  // Index 0 exits before any decrement, so the counter never wraps.
  always_comb begin
    done = (idx_q == '0) || (EARLY_EXIT && (g_nxt || l_nxt));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      gt_q      <= 1'b0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      {G, E, L} <= 3'b000;
    end else begin
      valid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            idx_q   <= LastIdx;
            gt_q    <= 1'b0;
            eq_q    <= 1'b1;
            lt_q    <= 1'b0;
            busy    <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (done) begin
            {G, E, L} <= g_nxt ? RES_GT : (l_nxt ? RES_LT : RES_EQ);
            valid     <= 1'b1;
            busy      <= 1'b0;
            state_q   <= ST_IDLE;
          end else begin
            idx_q <= idx_q - IdxW'(1);
            gt_q  <= g_nxt;
            eq_q  <= e_nxt;
            lt_q  <= l_nxt;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Drives four comparator configurations from shared stimulus and checks each against an
// arithmetic transaction model every cycle, plus directed latency/result expectations.
module tb_serial_mag_comparator;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic [3:0] a     = 4'd0;
  logic [3:0] b     = 4'd0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Expected {G,E,L} from integer comparison of the low w bits.
  function automatic logic [2:0] exp_res(input logic [3:0] av, input logic [3:0] bv,
                                         input int w, input bit s);
    int ia;
    int ib;
    ia = int'(av) & ((1 << w) - 1);
    ib = int'(bv) & ((1 << w) - 1);
    if (s && av[w-1]) ia -= (1 << w);
    if (s && bv[w-1]) ib -= (1 << w);
    if (ia > ib) return 3'b100;
    if (ia == ib) return 3'b010;
    return 3'b001;
  endfunction

  // Bits examined: up to and including the most significant differing bit.
  function automatic int exp_k(input logic [3:0] av, input logic [3:0] bv,
                               input int w, input bit ee);
    if (!ee) return w;
    for (int i = w - 1; i >= 0; i--) begin
      if (av[i] != bv[i]) return w - i;
    end
    return w;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  for (genvar c = 0; c < 4; c++) begin : g_cfg
    localparam int unsigned W  = (c == 3) ? 1 : 4;
    localparam bit          S  = (c >= 2);
    localparam bit          EE = (c != 1);

    logic       busy;
    logic       valid;
    logic       G;
    logic       E;
    logic       L;
    logic       m_busy;
    logic       m_valid;
    logic [2:0] m_res;
    logic [2:0] m_pend;
    int         m_cnt;

    serial_mag_comparator #(
      .WIDTH      (W),
      .SIGNED     (S),
      .EARLY_EXIT (EE)
    ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a[W-1:0]),
      .b     (b[W-1:0]),
      .busy  (busy),
      .valid (valid),
      .G     (G),
      .E     (E),
      .L     (L)
    );

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b0;
        m_res   <= 3'b000;
        m_pend  <= 3'b000;
        m_cnt   <= 0;
      end else begin
        m_valid <= 1'b0;
        if (!m_busy) begin
          if (start) begin
            m_busy <= 1'b1;
            m_cnt  <= exp_k(a, b, W, EE);
            m_pend <= exp_res(a, b, W, S);
          end
        end else if (m_cnt == 1) begin
          m_busy  <= 1'b0;
          m_valid <= 1'b1;
          m_res   <= m_pend;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  task automatic cmp_cfg(input string tag, input logic bz, input logic vd,
                         input logic [2:0] gel, input logic mb, input logic mv,
                         input logic [2:0] mr);
    chk({tag, " busy"}, {7'd0, bz}, {7'd0, mb});
    chk({tag, " valid"}, {7'd0, vd}, {7'd0, mv});
    chk({tag, " gel"}, {5'd0, gel}, {5'd0, mr});
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      cmp_cfg("cfg0", g_cfg[0].busy, g_cfg[0].valid, {g_cfg[0].G, g_cfg[0].E, g_cfg[0].L},
              g_cfg[0].m_busy, g_cfg[0].m_valid, g_cfg[0].m_res);
      cmp_cfg("cfg1", g_cfg[1].busy, g_cfg[1].valid, {g_cfg[1].G, g_cfg[1].E, g_cfg[1].L},
              g_cfg[1].m_busy, g_cfg[1].m_valid, g_cfg[1].m_res);
      cmp_cfg("cfg2", g_cfg[2].busy, g_cfg[2].valid, {g_cfg[2].G, g_cfg[2].E, g_cfg[2].L},
              g_cfg[2].m_busy, g_cfg[2].m_valid, g_cfg[2].m_res);
      cmp_cfg("cfg3", g_cfg[3].busy, g_cfg[3].valid, {g_cfg[3].G, g_cfg[3].E, g_cfg[3].L},
              g_cfg[3].m_busy, g_cfg[3].m_valid, g_cfg[3].m_res);
    end
  end

  task automatic launch(input logic [3:0] av, input logic [3:0] bv);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid0(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!g_cfg[0].valid && k < 20);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((g_cfg[0].busy || g_cfg[1].busy || g_cfg[2].busy || g_cfg[3].busy) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("idle timeout", 8'd1, 8'd0);
    @(negedge clk);
  endtask

  function automatic logic [7:0] gel0();
    return {5'd0, g_cfg[0].G, g_cfg[0].E, g_cfg[0].L};
  endfunction

  initial begin
    int k;
    int nv;

    repeat (2) @(negedge clk);
    chk("reset busy0", {7'd0, g_cfg[0].busy}, 8'd0);
    chk("reset valid0", {7'd0, g_cfg[0].valid}, 8'd0);
    chk("reset gel2", {5'd0, g_cfg[2].G, g_cfg[2].E, g_cfg[2].L}, 8'd0);
    rst = 1'b0;
    @(negedge clk);

    chk("model k 5v6", 8'(exp_k(4'd5, 4'd6, 4, 1'b1)), 8'd3);
    chk("model signed 8v7", {5'd0, exp_res(4'd8, 4'd7, 4, 1'b1)}, 8'b001);
    chk("model unsigned 8v7", {5'd0, exp_res(4'd8, 4'd7, 4, 1'b0)}, 8'b100);
    chk("model w1 signed 1v0", {5'd0, exp_res(4'd1, 4'd0, 1, 1'b1)}, 8'b001);

    // Equal operands scan every bit.
    launch(4'd9, 4'd9);
    chk("t1 busy after start", {7'd0, g_cfg[0].busy}, 8'd1);
    wait_valid0(k);
    chk("t1 latency", 8'(k), 8'd4);
    chk("t1 gel", gel0(), 8'b010);
    wait_idle();

    // MSB differs: early exit after one bit; full scan config still takes four.
    launch(4'd12, 4'd3);
    wait_valid0(k);
    chk("t2 latency", 8'(k), 8'd1);
    chk("t2 gel", gel0(), 8'b100);
    wait_idle();
    chk("t2 full-scan gel", {5'd0, g_cfg[1].G, g_cfg[1].E, g_cfg[1].L}, 8'b100);

    // Difference at bit 1, then a start issued in the valid cycle.
    launch(4'd5, 4'd6);
    wait_valid0(k);
    chk("t3a latency", 8'(k), 8'd3);
    chk("t3a gel", gel0(), 8'b001);
    launch(4'd6, 4'd5);
    wait_valid0(k);
    chk("t3b latency", 8'(k), 8'd3);
    chk("t3b gel", gel0(), 8'b100);
    wait_idle();

    // -8 vs +7 signed, 8 vs 7 unsigned.
    launch(4'b1000, 4'b0111);
    wait_valid0(k);
    chk("t4 latency", 8'(k), 8'd1);
    chk("t4 unsigned gel", gel0(), 8'b100);
    wait_idle();
    chk("t4 signed gel", {5'd0, g_cfg[2].G, g_cfg[2].E, g_cfg[2].L}, 8'b001);
    chk("t4 w1 signed gel", {5'd0, g_cfg[3].G, g_cfg[3].E, g_cfg[3].L}, 8'b100);

    // Start pulse while busy must be ignored.
    launch(4'd9, 4'd9);
    @(negedge clk);
    a     = 4'd12;
    b     = 4'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid0(k);
    chk("t5 latency", 8'(k), 8'd2);
    chk("t5 gel", gel0(), 8'b010);
    nv = 0;
    repeat (8) begin
      @(negedge clk);
      if (g_cfg[0].valid) nv++;
    end
    chk("t5 extra valids", 8'(nv), 8'd0);
    wait_idle();

    // Reset in the middle of a compare.
    launch(4'd3, 4'd3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6 busy in reset", {7'd0, g_cfg[0].busy}, 8'd0);
    chk("t6 valid in reset", {7'd0, g_cfg[0].valid}, 8'd0);
    chk("t6 gel in reset", gel0(), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    nv = 0;
    repeat (6) begin
      @(negedge clk);
      if (g_cfg[0].valid) nv++;
    end
    chk("t6 valids after reset", 8'(nv), 8'd0);
    launch(4'd2, 4'd1);
    wait_valid0(k);
    chk("t6 latency", 8'(k), 8'd3);
    chk("t6 gel", gel0(), 8'b100);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
